// File: rtl/jtkicker_sdram_pkg.sv
// Shared constants for the jtkicker SDRAM responder model.
// Contents: FSM state encodings, refresh stall length, byte write-enable helper.
package jtkicker_sdram_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_RD_DONE = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_REFRESH = 3'd5;

  // Cycles spent in REFRESH once a refresh is taken
  localparam int REFRESH_LEN = 4;

  // prog_mask is active low; no byte is written unless the write is accepted
  function automatic logic [1:0] byte_we(input logic [1:0] mask, input logic en);
    return en ? ~mask : 2'b00;
  endfunction

endpackage

// File: rtl/jtkicker_sdram_mem.sv
// 2^AW x 16 single-port RAM with per-byte write enables.
// Ports:
//   clk    system clock
//   we     byte write enables (bit1 = high byte, bit0 = low byte)
//   addr   word address shared by read and write
//   wdata  write word
//   q      read word (combinational from addr)
module jtkicker_sdram_mem #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   q
);

  logic [15:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
  end

  // The responder registers the word itself, so an async read keeps the
  // first data word exactly LATENCY cycles after the ack.
  assign q = mem[addr];

endmodule

// File: rtl/jtkicker_sdram_resp.sv
// Behavioural SDRAM responder: serves burst reads on the game side and
// byte-masked writes from the ROM downloader, out of a 2^AW x 16 store.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   downloading           selects the write path (1) or read path (0)
//   sdram_req/addr/ack    read request, word address, one-cycle accept
//   data_dst/rdy/read     per-word valid, burst-done pulse, data word
//   prog_addr/data/mask   download word address, byte, active-low enables
//   prog_we/prog_rd       download write strobe; prog_rd is ignored
// Optional macro JTKICKER_SDRAM_REFRESH_EN adds periodic 4-cycle refresh
// stalls every REFRESH_PERIOD cycles.
module jtkicker_sdram_resp
  import jtkicker_sdram_pkg::*;
#(
  parameter int AW             = 16,
  parameter int LATENCY        = 4,
  parameter int BURST          = 2,
  parameter int REFRESH_PERIOD = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic        data_dst,
  output logic        data_rdy,
  output logic [15:0] data_read,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  input  logic        prog_rd
);

  logic [2:0]    state;
  logic [3:0]    lat_cnt;   // read latency, reused for the refresh stall
  logic [1:0]    beat;      // words issued in the current burst
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_word;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_we;
  logic [15:0]   mem_q;
  logic          refresh_pend;
  logic          idle_free;
  logic          wr_go;
  logic          rd_go;
  logic          unused_bits;

  assign unused_bits = ^{prog_rd, sdram_addr, prog_addr, REFRESH_PERIOD != 0};

`ifdef JTKICKER_SDRAM_REFRESH_EN
  localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  logic [RW-1:0] rf_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_cnt       <= '0;
      refresh_pend <= 1'b0;
    end else begin
      if (state == ST_IDLE && refresh_pend) refresh_pend <= 1'b0;
      if (rf_cnt == RW'(REFRESH_PERIOD-1)) begin
        rf_cnt       <= '0;
        refresh_pend <= 1'b1;
      end else begin
        rf_cnt <= rf_cnt + 1'b1;
      end
    end
  end
`else
  assign refresh_pend = 1'b0;
`endif

  // Downloading selects exactly one path, so a simultaneous write and read
  // resolve by that level alone; the other request just stays pending.
  assign idle_free = (state == ST_IDLE) && !refresh_pend;
  assign wr_go     = idle_free && prog_we && downloading;
  assign rd_go     = idle_free && sdram_req && !downloading;

  assign rd_word   = rd_addr + AW'(beat);  // wraps at 2^AW
  assign mem_addr  = (state == ST_IDLE) ? prog_addr[AW-1:0] : rd_word;
  assign mem_we    = byte_we(prog_mask, wr_go);

  jtkicker_sdram_mem #(.AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata ({prog_data, prog_data}),
    .q     (mem_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sdram_ack <= 1'b0;
      data_dst  <= 1'b0;
      data_rdy  <= 1'b0;
      data_read <= 16'h0;
      lat_cnt   <= '0;
      beat      <= '0;
      rd_addr   <= '0;
    end else begin
      sdram_ack <= 1'b0;
      data_rdy  <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef JTKICKER_SDRAM_REFRESH_EN
          if (refresh_pend) begin
            lat_cnt <= 4'(REFRESH_LEN-1);
            state   <= ST_REFRESH;
          end else
`endif
          if (wr_go) begin
            sdram_ack <= 1'b1;
            state     <= ST_WR;
          end else if (rd_go) begin
            sdram_ack <= 1'b1;
            rd_addr   <= sdram_addr[AW-1:0];
            lat_cnt   <= 4'(LATENCY-1);
            beat      <= '0;
            state     <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // Fires on the LATENCY-th edge after the ack edge
          if (lat_cnt == 4'd0) begin
            data_dst  <= 1'b1;
            data_read <= mem_q;
            beat      <= 2'd1;
            state     <= ST_RD_DATA;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (beat == 2'(BURST)) begin
            data_dst <= 1'b0;
            data_rdy <= 1'b1;
            state    <= ST_RD_DONE;
          end else begin
            data_read <= mem_q;
            beat      <= beat + 1'b1;
          end
        end
        ST_RD_DONE: state <= ST_IDLE;
        ST_WR:      state <= ST_IDLE;
`ifdef JTKICKER_SDRAM_REFRESH_EN
        ST_REFRESH: begin
          if (lat_cnt == 4'd0) state   <= ST_IDLE;
          else                 lat_cnt <= lat_cnt - 1'b1;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkicker_sdram_resp.sv
module tb_jtkicker_sdram_resp;
  localparam int AW    = 16;
  localparam int LAT   = 4;
  localparam int BURST = 2;

  logic        clk = 1'b0;
  logic        rst, downloading, sdram_req, sdram_ack, data_dst, data_rdy;
  logic [21:0] sdram_addr, prog_addr;
  logic [15:0] data_read;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we, prog_rd;

  int checks = 0;
  int errors = 0;
  logic [15:0] model [int];   // known word contents, keyed by wrapped address

  jtkicker_sdram_resp #(.AW(AW), .LATENCY(LAT), .BURST(BURST), .REFRESH_PERIOD(384)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_rd(prog_rd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int wrap_key(input logic [21:0] a, input int k);
    return (int'(a[AW-1:0]) + k) % (1 << AW);
  endfunction

  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
    int n;
    int key;
    downloading = 1'b1; prog_addr = a; prog_data = d; prog_mask = m; prog_we = 1'b1;
    n = 0;
    do begin step(); n++; end while (!sdram_ack && n < 20);
    prog_we = 1'b0;
    chk("wr_ack_lat", n, 1);
    key = wrap_key(a, 0);
    if (model.exists(key)) begin
      if (!m[1]) model[key][15:8] = d;
      if (!m[0]) model[key][7:0]  = d;
    end else if (m == 2'b00) begin
      model[key] = {d, d};
    end
    step();
    chk("wr_no_reack", sdram_ack, 1'b0);
  endtask

  // Observes the cycles after an ack: words at ack+LAT.., done pulse after them
  task automatic follow_read(input logic [21:0] a, input bit mid_dl,
                             output logic [15:0] w0, output logic [15:0] w1);
    logic [31:0] dp, rp;
    logic [15:0] last;
    int akc, k, key;
    dp = '0; rp = '0; akc = 0; last = 16'h0; w0 = 16'h0; w1 = 16'h0;
    for (int c = 1; c <= LAT + BURST + 1; c++) begin
      if (mid_dl && c == 2) downloading = 1'b1;
      step();
      dp[c] = data_dst; rp[c] = data_rdy; akc += int'(sdram_ack);
      if (data_dst) begin
        k = c - LAT;
        key = wrap_key(a, k);
        if (k == 0) w0 = data_read;
        if (k == 1) w1 = data_read;
        if (model.exists(key)) chk("rd_word", data_read, model[key]);
        last = data_read;
      end
    end
    chk("rd_dst_pattern", dp, ((32'd1 << BURST) - 1) << LAT);
    chk("rd_rdy_pattern", rp, 32'd1 << (LAT + BURST));
    chk("rd_no_extra_ack", akc, 0);
    chk("rd_data_hold", data_read, last);
    downloading = 1'b0;
  endtask

  task automatic do_read(input logic [21:0] a, input bit mid_dl,
                         output logic [15:0] w0, output logic [15:0] w1);
    int n;
    downloading = 1'b0; sdram_addr = a; sdram_req = 1'b1;
    n = 0;
    do begin step(); n++; end while (!sdram_ack && n < 20);
    sdram_req = 1'b0;
    chk("rd_ack_lat", n, 1);
    follow_read(a, mid_dl, w0, w1);
  endtask

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [15:0] pool [12];
    logic [15:0] w0, w1;
    int akc, dc, first, second;

    tbl[0] = '{22'h000010, 8'hA5, 2'b00, 16'hA5A5};
    tbl[1] = '{22'h000010, 8'h5A, 2'b10, 16'hA55A};
    tbl[2] = '{22'h000010, 8'h3C, 2'b01, 16'h3C5A};
    tbl[3] = '{22'h000010, 8'hFF, 2'b11, 16'h3C5A};
    tbl[4] = '{22'h3C0010, 8'h11, 2'b00, 16'h1111};
    tbl[5] = '{22'h000011, 8'h77, 2'b00, 16'h7777};
    pool = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0012, 16'h0013,
             16'h1234, 16'h1235, 16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF};

    rst = 1'b1; downloading = 1'b0; sdram_req = 1'b0; sdram_addr = '0;
    prog_addr = '0; prog_data = '0; prog_mask = 2'b11; prog_we = 1'b0; prog_rd = 1'b0;
    repeat (3) step();
    chk("reset_ctl", {sdram_ack, data_dst, data_rdy}, 3'b000);
    chk("reset_data", data_read, 16'h0);
    rst = 1'b0;
    step();

    // Masked downloads, each read back
    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
      do_read(tbl[i].addr, 1'b0, w0, w1);
      chk("tbl_word", w0, tbl[i].exp);
    end

    // Burst crossing the top of the address space
    do_write(22'h00FFFF, 8'hC3, 2'b00);
    do_write(22'h000000, 8'h81, 2'b00);
    do_read(22'h3FFFFF, 1'b0, w0, w1);
    chk("wrap_w0", w0, 16'hC3C3);
    chk("wrap_w1", w1, 16'h8181);

    // Read held while downloading: no ack until downloading falls
    downloading = 1'b1; sdram_addr = 22'h10; sdram_req = 1'b1; akc = 0;
    repeat (5) begin step(); akc += int'(sdram_ack); end
    chk("gate_rd_noack", akc, 0);
    downloading = 1'b0;
    step();
    chk("gate_rd_ack", sdram_ack, 1'b1);
    sdram_req = 1'b0;
    follow_read(22'h10, 1'b0, w0, w1);

    // Write held while not downloading must not land
    do_write(22'h20, 8'h44, 2'b00);
    downloading = 1'b0; prog_addr = 22'h20; prog_data = 8'h99; prog_mask = 2'b00; prog_we = 1'b1; akc = 0;
    repeat (5) begin step(); akc += int'(sdram_ack); end
    chk("gate_wr_noack", akc, 0);
    prog_we = 1'b0;
    do_read(22'h20, 1'b0, w0, w1);
    chk("gate_wr_nowrite", w0, 16'h4444);

    // Simultaneous write and read while downloading: write wins, read stays pending
    downloading = 1'b1; prog_addr = 22'h30; prog_data = 8'h66; prog_mask = 2'b00; prog_we = 1'b1;
    sdram_addr = 22'h10; sdram_req = 1'b1;
    step();
    chk("prio_wr_ack", sdram_ack, 1'b1);
    prog_we = 1'b0; model[16'h30] = 16'h6666;
    akc = 0; dc = 0;
    repeat (8) begin step(); akc += int'(sdram_ack); dc += int'(data_dst | data_rdy); end
    chk("prio_rd_pending", akc + dc, 0);
    sdram_req = 1'b0;
    do_read(22'h30, 1'b0, w0, w1);
    chk("prio_wr_data", w0, 16'h6666);

    // Request held continuously: acks spaced by at least LAT+BURST+1
    downloading = 1'b0; sdram_addr = 22'h10; sdram_req = 1'b1; first = -1; second = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (sdram_ack) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    sdram_req = 1'b0;
    chk("b2b_first_ack", first, 1);
    chk("b2b_spacing", (second > 0 && second - first >= LAT + BURST + 1), 1);
    repeat (12) step();

    // Reset mid-burst: no data, no done, outputs cleared, memory retained
    downloading = 1'b0; sdram_addr = 22'h10; sdram_req = 1'b1;
    step();
    chk("rstmid_ack", sdram_ack, 1'b1);
    sdram_req = 1'b0; dc = 0;
    repeat (3) begin step(); dc += int'(data_dst | data_rdy); end
    rst = 1'b1;
    step();
    chk("rstmid_out", {sdram_ack, data_dst, data_rdy, data_read}, 19'h0);
    rst = 1'b0;
    repeat (8) begin step(); dc += int'(data_dst | data_rdy); end
    chk("rstmid_quiet", dc, 0);
    do_read(22'h10, 1'b0, w0, w1);
    chk("mem_kept", w0, 16'h1111);

    // Random traffic against the model
    foreach (pool[i]) do_write({6'($urandom), pool[i]}, 8'($urandom), 2'b00);
    for (int i = 0; i < 40; i++) begin
      logic [21:0] a;
      a = {6'($urandom), pool[$urandom_range(0, 11)]};
      if ($urandom_range(0, 2) == 0)
        do_write(a, 8'($urandom), 2'($urandom));
      else
        do_read(a, $urandom_range(0, 3) == 0, w0, w1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
